// File: rtl/hazard_pkg.sv
// Shared types and field offsets for the pipeline hazard control unit.
// - state_t   : memory-wait freeze FSM states
// - fwd_sel_t : ALU operand forwarding select encoding
// - S_*/M_*   : bit offsets into the hazard_singles / hazard_mults buses
// - regMatch  : register compare where register 0 never matches
package hazard_pkg;

  typedef enum logic {
    RUN,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam int unsigned REG_W = 5;

  // hazard_singles bit positions
  localparam int unsigned S_MEMTOREG_E = 4;
  localparam int unsigned S_REGWRITE_E = 3;
  localparam int unsigned S_MEMTOREG_M = 2;
  localparam int unsigned S_REGWRITE_M = 1;
  localparam int unsigned S_REGWRITE_W = 0;

  // hazard_mults field LSB positions (each REG_W wide)
  localparam int unsigned M_RS_D = 30;
  localparam int unsigned M_RT_D = 25;
  localparam int unsigned M_RS_E = 20;
  localparam int unsigned M_RT_E = 15;
  localparam int unsigned M_WR_E = 10;
  localparam int unsigned M_WR_M = 5;
  localparam int unsigned M_WR_W = 0;

  // $zero is hard-wired, so a dependency on it is never a hazard.
  function automatic logic regMatch(input logic [REG_W-1:0] a,
                                    input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Pure combinational hazard detection for the 5-stage pipeline.
// Inputs : BranchD, singles (control bits), mults (register numbers)
// Outputs: forwardAE/BE (ALU operand select), forwardAD/BD (branch compare
//          select), lwStall (load-use), branchStall (branch operand not ready)
module hazard_detect
  import hazard_pkg::*;
(
  input  logic                BranchD,
  input  logic [4:0]          singles,
  input  logic [34:0]         mults,
  output fwd_sel_t            forwardAE,
  output fwd_sel_t            forwardBE,
  output logic                forwardAD,
  output logic                forwardBD,
  output logic                lwStall,
  output logic                branchStall
);

  logic [REG_W-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
  logic             memtoRegE, regWriteE, memtoRegM, regWriteM, regWriteW;

  assign rsD = mults[M_RS_D +: REG_W];
  assign rtD = mults[M_RT_D +: REG_W];
  assign rsE = mults[M_RS_E +: REG_W];
  assign rtE = mults[M_RT_E +: REG_W];
  assign wrE = mults[M_WR_E +: REG_W];
  assign wrM = mults[M_WR_M +: REG_W];
  assign wrW = mults[M_WR_W +: REG_W];

  assign memtoRegE = singles[S_MEMTOREG_E];
  assign regWriteE = singles[S_REGWRITE_E];
  assign memtoRegM = singles[S_MEMTOREG_M];
  assign regWriteM = singles[S_REGWRITE_M];
  assign regWriteW = singles[S_REGWRITE_W];

  // Memory stage holds the newer value, so it wins over Writeback.
  function automatic fwd_sel_t fwdSel(input logic [REG_W-1:0] src);
    if (regWriteM && regMatch(src, wrM))      return FWD_M;
    else if (regWriteW && regMatch(src, wrW)) return FWD_W;
    else                                      return FWD_RF;
  endfunction

  always_comb begin
    forwardAE   = fwdSel(rsE);
    forwardBE   = fwdSel(rtE);
    forwardAD   = regWriteM && regMatch(rsD, wrM);
    forwardBD   = regWriteM && regMatch(rtD, wrM);
    lwStall     = memtoRegE && (regMatch(rtE, rsD) || regMatch(rtE, rtD));
    branchStall = BranchD &&
                  ((regWriteE && (regMatch(wrE, rsD) || regMatch(wrE, rtD))) ||
                   (memtoRegM && (regMatch(wrM, rsD) || regMatch(wrM, rtD))));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control unit for the 5-stage MIPS pipeline.
// Combinational stall/flush/forward outputs from hazard_detect, plus a
// memory-wait freeze FSM, a wait watchdog and saturating perf counters.
// Ports:
//   clk, reset (sync, active-high), enable (counter/watchdog advance)
//   BranchD, MemWriteM, MemReadyM, hazard_singles[4:0], hazard_mults[34:0]
//   StallF/D/E/M/W, FlushE, ForwardAD/BD, ForwardAE/BE[1:0]
//   stall_cnt, memwait_cnt (CNT_W), mem_timeout (sticky)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             BranchD,
  input  logic             MemWriteM,
  input  logic             MemReadyM,
  input  logic [4:0]       hazard_singles,
  input  logic [34:0]      hazard_mults,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  fwd_sel_t          fwdAE, fwdBE;
  logic              fwdAD, fwdBD, lwStall, branchStall, anyStall, memWait;
  state_t            state, stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  stallCnt, memWaitCnt;
  logic              timeoutFlag;

  hazard_detect uDetect (
    .BranchD     (BranchD),
    .singles     (hazard_singles),
    .mults       (hazard_mults),
    .forwardAE   (fwdAE),
    .forwardBE   (fwdBE),
    .forwardAD   (fwdAD),
    .forwardBD   (fwdBD),
    .lwStall     (lwStall),
    .branchStall (branchStall)
  );

  assign anyStall = lwStall | branchStall;
  assign memWait  = (hazard_singles[S_MEMTOREG_M] | MemWriteM) & ~MemReadyM;

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (memWait)  stateNext = WAIT;
      WAIT:    if (!memWait) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      stallCnt    <= '0;
      memWaitCnt  <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      state <= stateNext;
      // waitCnt counts completed frozen cycles of the current wait episode.
      if (!memWait)
        waitCnt <= '0;
      else if (enable && waitCnt != WAIT_MAX)
        waitCnt <= waitCnt + WAIT_ONE;
      // Edge closing the TIMEOUT-th consecutive frozen cycle.
      if (enable && memWait && waitCnt == WAIT_MAX - WAIT_ONE)
        timeoutFlag <= 1'b1;
      if (enable && anyStall && stallCnt != '1)
        stallCnt <= stallCnt + CNT_ONE;
      if (enable && memWait && memWaitCnt != '1)
        memWaitCnt <= memWaitCnt + CNT_ONE;
    end
  end

  // Memory freeze holds the whole pipe and must not flush the D-E bubble;
  // every output is forced low while reset is asserted.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushE    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      if (memWait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
      end else begin
        StallF = anyStall;
        StallD = anyStall;
        FlushE = anyStall;
      end
      ForwardAD = fwdAD;
      ForwardBD = fwdBD;
      ForwardAE = fwdAE;
      ForwardBE = fwdBE;
    end
  end

  assign stall_cnt   = reset ? '0 : stallCnt;
  assign memwait_cnt = reset ? '0 : memWaitCnt;
  assign mem_timeout = reset ? 1'b0 : timeoutFlag;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational vectors plus
// hand-written multi-cycle sequences (counters, freeze, watchdog, reset).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, BranchD, MemWriteM, MemReadyM;
  logic [4:0]  hazard_singles;
  logic [34:0] hazard_mults;
  logic        StallF, StallD, StallE, StallM, StallW, FlushE, ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, memwait_cnt;
  logic        mem_timeout;

  int unsigned nVec = 0;
  int unsigned nErr = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .BranchD(BranchD),
    .MemWriteM(MemWriteM), .MemReadyM(MemReadyM),
    .hazard_singles(hazard_singles), .hazard_mults(hazard_mults),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .StallW(StallW), .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .stall_cnt(stall_cnt),
    .memwait_cnt(memwait_cnt), .mem_timeout(mem_timeout)
  );

  typedef struct {
    logic [4:0]  singles;
    logic [34:0] mults;
    logic        branchD;
    logic        memWrite;
    logic        memReady;
    logic [11:0] expOut;
  } vec_t;

  vec_t tbl[14];

  // Output packing: {StallF,D,E,M,W,FlushE, AD,BD, AE[1:0], BE[1:0]}
  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_HAZ  = 6'b110001;
  localparam logic [5:0] ST_FRZ  = 6'b111110;

  function automatic logic [34:0] mk(input logic [4:0] rsD, input logic [4:0] rtD,
                                     input logic [4:0] rsE, input logic [4:0] rtE,
                                     input logic [4:0] wE, input logic [4:0] wM,
                                     input logic [4:0] wW);
    return {rsD, rtD, rsE, rtE, wE, wM, wW};
  endfunction

  function automatic vec_t v(input logic [4:0] s, input logic [34:0] m, input logic b,
                             input logic mw, input logic mr, input logic [11:0] e);
    vec_t r;
    r.singles = s; r.mults = m; r.branchD = b; r.memWrite = mw; r.memReady = mr;
    r.expOut = e;
    return r;
  endfunction

  function automatic logic [11:0] outs();
    return {StallF, StallD, StallE, StallM, StallW, FlushE,
            ForwardAD, ForwardBD, ForwardAE, ForwardBE};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; sample mid-cycle.
  task automatic step(input logic [4:0] s, input logic [34:0] m, input logic b,
                      input logic mw, input logic mr, input logic rst);
    @(posedge clk);
    #1;
    hazard_singles = s; hazard_mults = m; BranchD = b;
    MemWriteM = mw; MemReadyM = mr; reset = rst;
    #2;
  endtask

  task automatic idle(input logic rst);
    step(5'b0, 35'b0, 1'b0, 1'b0, 1'b1, rst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; BranchD = 1'b0; MemWriteM = 1'b0; MemReadyM = 1'b1;
    hazard_singles = '0; hazard_mults = '0;

    tbl[0]  = v(5'b00000, mk(0,0,0,0,0,0,0), 0, 0, 1, {ST_NONE, 2'b00, 2'b00, 2'b00});
    tbl[1]  = v(5'b00011, mk(0,0,5,0,0,5,5), 0, 0, 1, {ST_NONE, 2'b00, 2'b10, 2'b00});
    tbl[2]  = v(5'b00001, mk(0,0,5,0,0,5,5), 0, 0, 1, {ST_NONE, 2'b00, 2'b01, 2'b00});
    tbl[3]  = v(5'b00011, mk(0,0,0,0,0,0,0), 0, 0, 1, {ST_NONE, 2'b00, 2'b00, 2'b00});
    tbl[4]  = v(5'b00011, mk(0,0,0,7,0,7,7), 0, 0, 1, {ST_NONE, 2'b00, 2'b00, 2'b10});
    tbl[5]  = v(5'b00010, mk(9,10,0,0,0,9,0), 0, 0, 1, {ST_NONE, 2'b10, 2'b00, 2'b00});
    tbl[6]  = v(5'b00010, mk(0,10,0,0,0,10,0), 0, 0, 1, {ST_NONE, 2'b01, 2'b00, 2'b00});
    tbl[7]  = v(5'b10000, mk(8,0,0,8,0,0,0), 0, 0, 1, {ST_HAZ, 2'b00, 2'b00, 2'b00});
    tbl[8]  = v(5'b10000, mk(0,4,0,4,0,0,0), 0, 0, 1, {ST_HAZ, 2'b00, 2'b00, 2'b00});
    tbl[9]  = v(5'b10000, mk(0,0,0,0,0,0,0), 0, 0, 1, {ST_NONE, 2'b00, 2'b00, 2'b00});
    tbl[10] = v(5'b01000, mk(3,0,0,0,3,0,0), 1, 0, 1, {ST_HAZ, 2'b00, 2'b00, 2'b00});
    tbl[11] = v(5'b00100, mk(0,6,0,0,0,6,0), 1, 0, 1, {ST_HAZ, 2'b00, 2'b00, 2'b00});
    tbl[12] = v(5'b10000, mk(8,0,0,8,0,0,0), 0, 1, 0, {ST_FRZ, 2'b00, 2'b00, 2'b00});
    tbl[13] = v(5'b00000, mk(3,0,0,0,3,0,0), 1, 0, 1, {ST_NONE, 2'b00, 2'b00, 2'b00});

    // Reset with load-use inputs present: outputs must still be low.
    step(5'b10000, mk(8,0,0,8,0,0,0), 0, 0, 1, 1);
    step(5'b10000, mk(8,0,0,8,0,0,0), 0, 0, 1, 1);
    chk("rst_outs", 32'(outs()), 32'h0);
    chk("rst_stallcnt", stall_cnt, 32'd0);
    idle(1'b0);
    chk("idle_outs", 32'(outs()), 32'h0);
    chk("idle_stallcnt", stall_cnt, 32'd0);
    chk("idle_memwaitcnt", memwait_cnt, 32'd0);
    chk("idle_timeout", 32'(mem_timeout), 32'd0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].singles, tbl[i].mults, tbl[i].branchD, tbl[i].memWrite,
           tbl[i].memReady, 1'b0);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].expOut));
    end

    // Load-use for one cycle only.
    idle(1'b1);
    step(5'b10000, mk(8,0,0,8,0,0,0), 0, 0, 1, 0);
    chk("lw_stall", 32'(outs()), 32'({ST_HAZ, 6'b0}));
    idle(1'b0);
    chk("lw_clear", 32'(outs()), 32'h0);
    chk("lw_stallcnt", stall_cnt, 32'd1);

    // Branch waits on E result, then forwards from M.
    step(5'b01000, mk(3,0,0,0,3,0,0), 1, 0, 1, 0);
    chk("br_stall", 32'(outs()), 32'({ST_HAZ, 6'b0}));
    step(5'b00010, mk(3,0,0,0,0,3,0), 1, 0, 1, 0);
    chk("br_fwdAD", 32'(outs()), 32'({ST_NONE, 2'b10, 4'b0}));
    idle(1'b0);
    chk("br_stallcnt", stall_cnt, 32'd2);

    // Memory freeze overrides load-use; forwarding stays live.
    for (int k = 0; k < 3; k++) begin
      step(5'b10110, mk(8,0,5,8,0,5,0), 0, 0, 0, 0);
      chk($sformatf("frz%0d", k), 32'(outs()), 32'({ST_FRZ, 2'b00, 2'b10, 2'b00}));
    end
    idle(1'b0);
    chk("frz_release", 32'(outs()), 32'h0);
    chk("frz_memwaitcnt", memwait_cnt, 32'd3);
    enable = 1'b0;
    step(5'b00100, 35'b0, 0, 0, 0, 0);
    chk("noen_frz", 32'(outs()), 32'({ST_FRZ, 6'b0}));
    idle(1'b0);
    chk("noen_memwaitcnt", memwait_cnt, 32'd3);
    enable = 1'b1;

    // Watchdog with reset in the 6th frozen cycle.
    idle(1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(5'b00000, 35'b0, 0, 1, 0, (k == 6));
      if (k <= 4)
        chk($sformatf("wd_cyc%0d", k), 32'(mem_timeout), 32'd0);
      else if (k == 5)
        chk("wd_cyc5", 32'(mem_timeout), 32'd1);
      else
        chk("wd_rst_outs", 32'({outs(), mem_timeout}), 32'd0);
    end
    step(5'b00000, 35'b0, 0, 1, 0, 0);
    chk("wd_after_rst_flag", 32'(mem_timeout), 32'd0);
    chk("wd_after_rst_cnt", memwait_cnt, 32'd0);
    chk("wd_after_rst_frz", 32'(outs()), 32'({ST_FRZ, 6'b0}));
    idle(1'b0);
    chk("wd_after_rst_cnt1", memwait_cnt, 32'd1);

    // Flag is sticky after the wait ends.
    idle(1'b1);
    for (int k = 0; k < 4; k++) step(5'b00000, 35'b0, 0, 1, 0, 0);
    idle(1'b0);
    chk("sticky1", 32'(mem_timeout), 32'd1);
    chk("sticky_cnt", memwait_cnt, 32'd4);
    idle(1'b0);
    chk("sticky2", 32'(mem_timeout), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
